// File: rtl/i2c_resp_collector_pkg.sv
// i2c_resp_collector_pkg: shared constants and FSM encoding for the response collector
package i2c_resp_collector_pkg;
  localparam int N = 12;
  localparam int CH_W = $clog2(N);
  localparam logic [7:0] SOF = 8'hA5;
  typedef enum logic [2:0] {IDLE, LATCH, HDR_SOF, HDR_CH, HDR_LEN, PAYLOAD, CSUM} state_t;
endpackage

// File: rtl/i2c_resp_collector_if.sv
// i2c_resp_collector_if: slave-FIFO side and host byte stream of the response collector
interface i2c_resp_collector_if;
  import i2c_resp_collector_pkg::*;
  logic [N-1:0] have_msg_bus;
  logic [N-1:0] busy_bus;
  logic [N-1:0] s_rdreq_bus;
  logic [7:0] len;
  logic [7:0] s_dout;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic busy;
  logic err_underrun;
  modport master (
    input have_msg_bus, busy_bus, len, s_dout, tx_ready,
    output s_rdreq_bus, tx_data, tx_valid, busy, err_underrun
  );
  modport slave (
    output have_msg_bus, busy_bus, len, s_dout, tx_ready,
    input s_rdreq_bus, tx_data, tx_valid, busy, err_underrun
  );
endinterface

// File: rtl/i2c_resp_collector_rr_arbiter.sv
// i2c_resp_collector_rr_arbiter: round-robin grant, first request scanning upward from ptr+1 with wrap
module i2c_resp_collector_rr_arbiter #(
  parameter int N = 12,
  parameter int CH_W = 4
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] grant,
  output logic            any_grant
);
  // Scan farthest first so the nearest request past ptr wins.
  always_comb begin
    grant = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) grant = CH_W'((int'(ptr) + k) % N);
  end
  assign any_grant = |req;
endmodule

// File: rtl/i2c_resp_collector.sv
// i2c_resp_collector: arbitrates among channel FIFOs and frames one as SOF/id/len/payload/xor packet
module i2c_resp_collector
  import i2c_resp_collector_pkg::*;
(
  input logic clk,
  input logic n_rst,
  i2c_resp_collector_if.master bus
);
  state_t state_q, state_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d, sel_q, sel_d, grant;
  logic [7:0] len_snap_q, len_snap_d, cnt_q, cnt_d, csum_q, csum_d, pay;
  logic urun_q, urun_d, any_grant, have_sel, last;
  i2c_resp_collector_rr_arbiter #(.N(N), .CH_W(CH_W)) u_arb (
    .req(bus.have_msg_bus & ~bus.busy_bus),
    .ptr(rr_ptr_q),
    .grant(grant),
    .any_grant(any_grant)
  );
  assign have_sel = bus.have_msg_bus[sel_q];
  assign pay = have_sel ? bus.s_dout : 8'h00;
  assign last = cnt_q == len_snap_q - 8'd1;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d = sel_q;
    len_snap_d = len_snap_q;
    cnt_d = cnt_q;
    csum_d = csum_q;
    urun_d = urun_q;
    bus.busy = state_q != IDLE;
    bus.tx_valid = state_q inside {HDR_SOF, HDR_CH, HDR_LEN, PAYLOAD, CSUM};
    bus.tx_data = state_q == HDR_SOF ? SOF :
                  state_q == HDR_CH  ? 8'(sel_q) :
                  state_q == HDR_LEN ? len_snap_q :
                  state_q == PAYLOAD ? pay : csum_q;
    bus.s_rdreq_bus = (state_q == PAYLOAD && have_sel && bus.tx_ready) ?
                      {{(N-1){1'b0}}, 1'b1} << sel_q : '0;
    bus.err_underrun = state_q == PAYLOAD && !have_sel && !urun_q;
    case (state_q)
      IDLE: if (any_grant) begin
        sel_d = grant;
        rr_ptr_d = grant;
        state_d = LATCH;
      end
      LATCH: begin
        len_snap_d = bus.len;
        cnt_d = '0;
        csum_d = '0;
        urun_d = 1'b0;
        state_d = bus.len == 8'd0 ? IDLE : HDR_SOF;
      end
      HDR_SOF: if (bus.tx_ready) state_d = HDR_CH;
      HDR_CH: if (bus.tx_ready) begin
        csum_d = csum_q ^ 8'(sel_q);
        state_d = HDR_LEN;
      end
      HDR_LEN: if (bus.tx_ready) begin
        csum_d = csum_q ^ len_snap_q;
        state_d = PAYLOAD;
      end
      PAYLOAD: begin
        urun_d = urun_q | !have_sel;
        if (bus.tx_ready) begin
          cnt_d = cnt_q + 8'd1;
          csum_d = csum_q ^ pay;
          state_d = last ? CSUM : PAYLOAD;
        end
      end
      CSUM: if (bus.tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      rr_ptr_q <= CH_W'(N - 1);
      sel_q <= '0;
      len_snap_q <= '0;
      cnt_q <= '0;
      csum_q <= '0;
      urun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q <= sel_d;
      len_snap_q <= len_snap_d;
      cnt_q <= cnt_d;
      csum_q <= csum_d;
      urun_q <= urun_d;
    end
endmodule

// File: tb/tb_i2c_resp_collector.sv
// tb_i2c_resp_collector: FIFO models plus a byte scoreboard checking framing, arbitration and corner cases
module tb_i2c_resp_collector;
  import i2c_resp_collector_pkg::*;
  typedef struct {logic [7:0] b; logic last;} exp_t;
  typedef struct {int ch; int n; logic [3:0][7:0] d; int mode; logic [7:0] csum;} vec_t;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  i2c_resp_collector_if ifc();
  i2c_resp_collector dut (.clk(clk), .n_rst(n_rst), .bus(ifc.master));
  exp_t exp_q[$];
  exp_t mon_e;
  int ch_q[$];
  logic [7:0] fifo [N][$];
  vec_t tbl [5];
  int checks = 0, errors = 0, pop_cnt = 0, acc_cnt = 0, err_cnt = 0, rdy_mode = 0, cur_ch = 0;
  logic [7:0] len_ovr = 8'h00;
  logic [N-1:0] pend_pop = '0;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive();
    cur_ch = ch_q.size() != 0 ? ch_q[0] : 0;
    for (int i = 0; i < N; i++) ifc.have_msg_bus[i] = fifo[i].size() != 0;
    ifc.len = len_ovr != 8'h00 ? len_ovr : 8'(fifo[cur_ch].size());
    ifc.s_dout = fifo[cur_ch].size() != 0 ? fifo[cur_ch][0] : 8'h00;
  endtask

  task automatic load(input int ch, input logic [3:0][7:0] d, input int n);
    for (int k = 0; k < n; k++) fifo[ch].push_back(d[k]);
  endtask

  task automatic expect_pkt(input int ch, input logic [3:0][7:0] d, input int n, input int pad, input logic [7:0] cs);
    exp_q.push_back('{b: SOF, last: 1'b0});
    exp_q.push_back('{b: 8'(ch), last: 1'b0});
    exp_q.push_back('{b: 8'(n + pad), last: 1'b0});
    for (int k = 0; k < n; k++) exp_q.push_back('{b: d[k], last: 1'b0});
    for (int k = 0; k < pad; k++) exp_q.push_back('{b: 8'h00, last: 1'b0});
    exp_q.push_back('{b: cs, last: 1'b1});
    ch_q.push_back(ch);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual_left=%0d required_left=0", nm, exp_q.size());
      exp_q.delete();
      ch_q.delete();
    end
  endtask

  // FIFO pops take effect just after the edge that saw s_rdreq.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (pend_pop[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
    pend_pop = '0;
    ifc.tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~ifc.tx_ready : 1'($urandom_range(0, 1));
    drive();
  end

  always @(negedge clk) begin
    if (!n_rst) prev_valid = 1'b0;
    else begin
      if (prev_valid && !prev_ready)
        chk("hold", {ifc.tx_valid, ifc.tx_data},
            {1'b1, (ifc.tx_data == 8'h00 && !ifc.have_msg_bus[cur_ch]) ? 8'h00 : prev_data});
      if (ifc.err_underrun) err_cnt++;
      if (ifc.s_rdreq_bus != '0) begin
        pop_cnt++;
        chk("pop", {ifc.s_rdreq_bus, ifc.tx_valid & ifc.tx_ready}, {N'(1) << cur_ch, 1'b1});
        pend_pop = ifc.s_rdreq_bus;
      end
      if (ifc.tx_valid && ifc.tx_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte actual=%0h required=none", ifc.tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("byte", ifc.tx_data, mon_e.b);
          if (mon_e.last) begin
            void'(ch_q.pop_front());
            drive();
          end
        end
      end
      prev_valid = ifc.tx_valid;
      prev_ready = ifc.tx_ready;
      prev_data = ifc.tx_data;
    end
  end

  initial begin
    int c;
    tbl[0] = '{ch: 3,  n: 2, d: {8'h00, 8'h00, 8'h22, 8'h11}, mode: 0, csum: 8'h32};
    tbl[1] = '{ch: 3,  n: 2, d: {8'h00, 8'h00, 8'h22, 8'h11}, mode: 1, csum: 8'h32};
    tbl[2] = '{ch: 7,  n: 3, d: {8'h00, 8'h03, 8'h02, 8'h01}, mode: 2, csum: 8'h04};
    tbl[3] = '{ch: 11, n: 1, d: {8'h00, 8'h00, 8'h00, 8'hFF}, mode: 0, csum: 8'hF5};
    tbl[4] = '{ch: 0,  n: 4, d: {8'hC3, 8'h3C, 8'hA5, 8'h5A}, mode: 2, csum: 8'h04};
    ifc.busy_bus = '0;
    ifc.tx_ready = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #3;
    chk("rst_tx_valid", ifc.tx_valid, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_rdreq", ifc.s_rdreq_bus, 0);
    chk("rst_err", ifc.err_underrun, 0);
    tick();
    n_rst = 1'b1;
    // rr_ptr starts at N-1, so channel 0 wins before channel 1
    load(0, {8'h00, 8'h00, 8'h00, 8'h01}, 1);
    load(1, {8'h00, 8'h00, 8'h03, 8'h02}, 2);
    expect_pkt(0, {8'h00, 8'h00, 8'h00, 8'h01}, 1, 0, 8'h00);
    expect_pkt(1, {8'h00, 8'h00, 8'h03, 8'h02}, 2, 0, 8'h02);
    drive();
    wait_done("rr_reset");
    tick();
    for (int i = 0; i < 5; i++) begin
      rdy_mode = tbl[i].mode;
      pop_cnt = 0;
      load(tbl[i].ch, tbl[i].d, tbl[i].n);
      expect_pkt(tbl[i].ch, tbl[i].d, tbl[i].n, 0, tbl[i].csum);
      drive();
      wait_done("table");
      chk("table_pops", pop_cnt, tbl[i].n);
      tick();
      chk("table_idle", ifc.busy, 0);
    end
    rdy_mode = 0;
    load(5, {8'h00, 8'h00, 8'h00, 8'h55}, 1);
    expect_pkt(5, {8'h00, 8'h00, 8'h00, 8'h55}, 1, 0, 8'h51);
    drive();
    wait_done("rr_pre");
    tick();
    load(0, {8'h00, 8'h00, 8'hC3, 8'hC2}, 2);
    load(5, {8'h00, 8'h00, 8'h00, 8'hC4}, 1);
    load(11, {8'h00, 8'h00, 8'h00, 8'hC1}, 1);
    expect_pkt(11, {8'h00, 8'h00, 8'h00, 8'hC1}, 1, 0, 8'hCB);
    expect_pkt(0, {8'h00, 8'h00, 8'hC3, 8'hC2}, 2, 0, 8'h03);
    expect_pkt(5, {8'h00, 8'h00, 8'h00, 8'hC4}, 1, 0, 8'hC0);
    drive();
    wait_done("rr_order");
    tick();
    ifc.busy_bus[2] = 1'b1;
    load(2, {8'h00, 8'h00, 8'h00, 8'h77}, 1);
    acc_cnt = 0;
    drive();
    repeat (10) tick();
    chk("gate_busy", ifc.busy, 0);
    chk("gate_bytes", acc_cnt, 0);
    expect_pkt(2, {8'h00, 8'h00, 8'h00, 8'h77}, 1, 0, 8'h74);
    drive();
    ifc.busy_bus[2] = 1'b0;
    c = 0;
    while (!ifc.tx_valid && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("gate_latency_le3", c <= 3, 1);
    wait_done("gate");
    tick();
    len_ovr = 8'd4;
    pop_cnt = 0;
    err_cnt = 0;
    load(4, {8'h00, 8'h00, 8'hBB, 8'hAA}, 2);
    expect_pkt(4, {8'h00, 8'h00, 8'hBB, 8'hAA}, 2, 2, 8'h11);
    drive();
    wait_done("underrun");
    chk("underrun_pops", pop_cnt, 2);
    chk("underrun_pulses", err_cnt, 1);
    len_ovr = 8'h00;
    tick();
    load(9, {8'h40, 8'h30, 8'h20, 8'h10}, 4);
    expect_pkt(9, {8'h40, 8'h30, 8'h20, 8'h10}, 4, 0, 8'h00);
    acc_cnt = 0;
    drive();
    c = 0;
    while (acc_cnt < 4 && c < 50) begin
      tick();
      c++;
    end
    chk("rst_mid_payload", acc_cnt >= 4, 1);
    #1 n_rst = 1'b0;
    #1;
    chk("rst_mid_valid", ifc.tx_valid, 0);
    chk("rst_mid_rdreq", ifc.s_rdreq_bus, 0);
    chk("rst_mid_busy", ifc.busy, 0);
    exp_q.delete();
    ch_q.delete();
    for (int i = 0; i < N; i++) fifo[i].delete();
    pend_pop = '0;
    drive();
    tick();
    tick();
    n_rst = 1'b1;
    load(9, {8'h00, 8'h00, 8'h00, 8'h10}, 1);
    expect_pkt(9, {8'h00, 8'h00, 8'h00, 8'h10}, 1, 0, 8'h18);
    drive();
    wait_done("after_reset");
    tick();
    chk("final_idle", ifc.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_resp_collector.md
Name: i2c_resp_collector

Overview:
- Downstream stage of the N-channel I2C bridge.
- Scans the per-channel "have message" flags and selects one channel using round-robin arbitration.
- Drains that channel's read-back bytes from its slave FIFO and frames them as one packet on a byte stream toward the host link.
- Packet format: SOF, channel id, length, payload, XOR checksum.

Parameters:
- N, 12, number of I2C channels.
- CH_W, 4, width of the channel index; must satisfy 2^CH_W >= N.
- SOF, 8'hA5, start-of-frame byte.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- have_msg_bus  input  N  per-channel slave FIFO non-empty.
- busy_bus  input  N  per-channel transaction in progress; the channel is not yet complete.
- len  input  8  byte count of the currently addressed slave FIFO.
- s_dout  input  8  head byte of the slave FIFO, show-ahead (valid while have_msg is high).
- s_rdreq_bus  output  N  one-hot pop strobe to the selected channel.
- tx_data  output  8  framed byte to the host link.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  host link accepts the byte (transfer occurs when tx_valid & tx_ready).
- busy  output  1  a packet is in progress.
- err_underrun  output  1  one-cycle pulse; the source FIFO emptied before len bytes were sent.

Behaviour:
- Reset is asynchronous on n_rst low. Reset values:
  - state = IDLE
  - rr_ptr = N-1
  - sel = 0
  - len_snap = 0, cnt = 0, csum = 0
  - tx_valid = 0, busy = 0, err_underrun = 0, s_rdreq_bus = 0
- Reset mid-packet aborts the packet silently; no checksum is emitted.
- Eligibility: eligible[i] = have_msg_bus[i] & !busy_bus[i].
- IDLE:
  - If any channel is eligible, select the first eligible index scanning upward from rr_ptr+1, wrapping at N-1 back to 0.
  - Register sel and rr_ptr <= sel. Go to LATCH.
- LATCH (one cycle, lets len settle to the selected channel):
  - len_snap <= len.
  - If len == 0, return to IDLE with no output.
  - Otherwise csum <= 0 and go to HDR_SOF.
- HDR_SOF, HDR_CH, HDR_LEN:
  - tx_valid = 1; tx_data is, in order, SOF, {zero-extend sel to 8 bits}, len_snap.
  - Advance to the next state only on tx_ready.
  - The CH and LEN bytes are XORed into csum when accepted.
- PAYLOAD, while have_msg_bus[sel] is high:
  - tx_data = s_dout, passed through combinationally; tx_valid = 1.
  - s_rdreq_bus = onehot(sel) & {N{tx_ready}}, so exactly one pop per accepted byte.
  - csum ^= s_dout on each accept; cnt increments on each accept.
  - When cnt reaches len_snap-1 and the byte is accepted, go to CSUM.
- PAYLOAD, while have_msg_bus[sel] is low (underrun):
  - tx_data = 8'h00, tx_valid = 1, no pop.
  - err_underrun pulses once per packet, on the first underrun cycle; padding continues until len_snap bytes have been sent.
- CSUM:
  - tx_data = csum, tx_valid = 1.
  - On tx_ready go to IDLE; busy falls the following cycle.
- tx_valid, once asserted, holds and tx_data stays stable until tx_ready. Exception: a PAYLOAD byte may change only if have_msg falls, i.e. it switches to the pad byte.
- busy = (state != IDLE).
- No back-to-back gap is required: IDLE may re-arbitrate in the cycle after CSUM completes.
- A channel that becomes eligible mid-packet waits its round-robin turn.
- Fairness: with all channels continuously eligible, successive packets go to consecutive indices, wrapping from N-1 to 0.
- Widths:
  - cnt and len_snap are 8 bits; len is 1..255, and no wrap occurs because cnt compares against len_snap-1.
  - csum is 8-bit XOR over the id byte, length byte and payload, excluding SOF.

Decomposition:
- Shared package/defines:
  - SOF value.
  - State encodings: IDLE, LATCH, HDR_SOF, HDR_CH, HDR_LEN, PAYLOAD, CSUM.
  - CH_W derivation.
- Sub-module rr_arbiter:
  - Inputs: N-bit request mask and rr_ptr.
  - Outputs: grant index and any_grant.
  - Combinational with a wrap-around priority scan; reusable by the host-side command router.

Test Plan:
- Single channel: channel 3 has 2 bytes 0x11,0x22, tx_ready held 1 -> stream A5 03 02 11 22 32; s_rdreq_bus = 0x008 for exactly 2 cycles; busy returns to 0.
- Backpressure: same as the previous test with tx_ready toggling 1,0,1,0 -> identical byte stream; each byte held stable while tx_ready is 0; no extra pops.
- Round-robin: channels 0, 5 and 11 all eligible, last served = 5 -> packets emitted in order 11, 0, 5.
- Busy gating: channel 2 has have_msg=1 and busy_bus[2]=1 -> no packet; release busy_bus[2] -> packet for channel 2 starts within 3 cycles.
- Underrun: len=4 but have_msg drops after 2 bytes (0xAA,0xBB) -> payload AA BB 00 00, checksum 04^4^AA^BB, err_underrun pulses once.
- Reset mid-PAYLOAD: n_rst asserted -> tx_valid, s_rdreq_bus and busy go to 0 immediately; after release, the next packet starts with A5.
